// File: rtl/alarm_input_cond.sv
// alarm_input_cond
//   Conditions the raw alarm-panel inputs for the alarm controller:
//   synchronizes the sensor contact and three push buttons, generates the
//   0.1 s tick, debounces every input on tick samples and turns button
//   presses into prioritised one-cycle pulses.
//
// Ports
//   clk         system clock
//   rst         synchronous active-high reset
//   raw_sensor  asynchronous sensor contact
//   raw_start   asynchronous arm button (high = pressed)
//   raw_cancel  asynchronous cancel button (high = pressed)
//   raw_test    asynchronous test button (high = pressed)
//   tick        one-cycle 0.1 s enable
//   sensor_o    debounced sensor level
//   start_p     one-cycle arm pulse
//   cancel_p    one-cycle cancel pulse
//   test_p      one-cycle test pulse
module alarm_input_cond #(
  parameter int CLK_DIV        = 5000000,
  parameter int DEB_TICKS      = 3,
  parameter int SENS_ON_TICKS  = 2,
  parameter int SENS_OFF_TICKS = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_sensor,
  input  logic raw_start,
  input  logic raw_cancel,
  input  logic raw_test,
  output logic tick,
  output logic sensor_o,
  output logic start_p,
  output logic cancel_p,
  output logic test_p
);

  localparam logic [23:0] DIV_LAST  = 24'(CLK_DIV - 1);
  localparam logic [7:0]  BTN_LAST  = 8'(DEB_TICKS - 1);
  localparam logic [7:0]  SENS_ON_LAST  = 8'(SENS_ON_TICKS - 1);
  localparam logic [7:0]  SENS_OFF_LAST = 8'(SENS_OFF_TICKS - 1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } btn_state_t;

  // Bit 0 sensor, bit 1 start, bit 2 cancel, bit 3 test.
  logic [3:0] raw_vec;
  logic [3:0] sync1_reg;
  logic [3:0] sync2_reg;

  assign raw_vec = {raw_test, raw_cancel, raw_start, raw_sensor};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= raw_vec;
      sync2_reg <= sync1_reg;
    end
  end

  // Tick divider
  logic [23:0] divider_reg;

  assign tick = (divider_reg == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      divider_reg <= '0;
    end else if (tick) begin
      divider_reg <= '0;
    end else begin
      divider_reg <= divider_reg + 24'd1;
    end
  end

  // Sensor debouncer: asymmetric thresholds, the one in force depends on
  // the level currently accepted.
  logic       sens_level_reg;
  logic [7:0] sens_cnt_reg;
  logic [7:0] sens_last;

  assign sens_last = sens_level_reg ? SENS_OFF_LAST : SENS_ON_LAST;
  assign sensor_o  = sens_level_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sens_level_reg <= 1'b0;
      sens_cnt_reg   <= '0;
    end else if (tick) begin
      if (sync2_reg[0] == sens_level_reg) begin
        sens_cnt_reg <= '0;
      end else if (sens_cnt_reg == sens_last) begin
        sens_level_reg <= ~sens_level_reg;
        sens_cnt_reg   <= '0;
      end else begin
        sens_cnt_reg <= sens_cnt_reg + 8'd1;
      end
    end
  end

  // Button debouncers. The FSM state encodes the debounced level
  // (PRESSED/RELEASE_WAIT = 1). btn_rise is a registered candidate pulse,
  // set only on the PRESS_WAIT -> PRESSED acceptance so that a rejected
  // release glitch (RELEASE_WAIT -> PRESSED) never pulses again.
  logic [2:0] btn_rise;   // 0 start, 1 cancel, 2 test

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      btn_state_t state_reg;
      btn_state_t state_next;
      logic [7:0] cnt_reg;
      logic [7:0] cnt_next;
      logic       rise_reg;
      logic       rise_next;
      logic       sample;

      assign sample       = sync2_reg[gi+1];
      assign btn_rise[gi] = rise_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg <= RELEASED;
          cnt_reg   <= '0;
          rise_reg  <= 1'b0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          rise_reg  <= rise_next;
        end
      end

      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        rise_next  = 1'b0;
        if (tick) begin
          case (state_reg)
            RELEASED, PRESS_WAIT: begin
              if (!sample) begin
                state_next = RELEASED;
                cnt_next   = '0;
              end else if (cnt_reg == BTN_LAST) begin
                state_next = PRESSED;
                cnt_next   = '0;
                rise_next  = 1'b1;
              end else begin
                state_next = PRESS_WAIT;
                cnt_next   = cnt_reg + 8'd1;
              end
            end
            PRESSED, RELEASE_WAIT: begin
              if (sample) begin
                state_next = PRESSED;
                cnt_next   = '0;
              end else if (cnt_reg == BTN_LAST) begin
                state_next = RELEASED;
                cnt_next   = '0;
              end else begin
                state_next = RELEASE_WAIT;
                cnt_next   = cnt_reg + 8'd1;
              end
            end
            default: begin
              state_next = RELEASED;
              cnt_next   = '0;
            end
          endcase
        end
      end
    end
  endgenerate

  // Priority cancel > start > test; losers are dropped, not queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_p  <= 1'b0;
      cancel_p <= 1'b0;
      test_p   <= 1'b0;
    end else begin
      cancel_p <= btn_rise[1];
      start_p  <= btn_rise[0] & ~btn_rise[1];
      test_p   <= btn_rise[2] & ~btn_rise[1] & ~btn_rise[0];
    end
  end

endmodule

// File: tb/tb_alarm_input_cond.sv
// tb_alarm_input_cond
//   Self-checking bench for alarm_input_cond with CLK_DIV=4, DEB_TICKS=3,
//   SENS_ON_TICKS=2, SENS_OFF_TICKS=5. Directed scenarios followed by a
//   randomized run, every cycle compared against a behavioural model that
//   works in terms of edges-since-reset, sample runs and pulse candidates.
module tb_alarm_input_cond;

  localparam int CLK_DIV = 4;
  localparam int DEB     = 3;
  localparam int SON     = 2;
  localparam int SOFF    = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic raw_sensor = 1'b0;
  logic raw_start  = 1'b0;
  logic raw_cancel = 1'b0;
  logic raw_test   = 1'b0;
  logic tick, sensor_o, start_p, cancel_p, test_p;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  alarm_input_cond #(
    .CLK_DIV(CLK_DIV),
    .DEB_TICKS(DEB),
    .SENS_ON_TICKS(SON),
    .SENS_OFF_TICKS(SOFF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .raw_sensor(raw_sensor),
    .raw_start(raw_start),
    .raw_cancel(raw_cancel),
    .raw_test(raw_test),
    .tick(tick),
    .sensor_o(sensor_o),
    .start_p(start_p),
    .cancel_p(cancel_p),
    .test_p(test_p)
  );

  // Reference model. Channel 0 sensor, 1 start, 2 cancel, 3 test.
  int       m_edge;
  bit [3:0] q_raw[$];
  bit       m_level[4];
  int       m_run[4];
  bit       m_cand[4];
  bit       e_tick, e_sensor, e_start, e_cancel, e_test;

  function automatic int need(int ch);
    if (ch == 0) return m_level[0] ? SOFF : SON;
    return DEB;
  endfunction

  task automatic model_edge();
    bit [3:0] raw_now;
    bit [3:0] synced;
    raw_now = {raw_test, raw_cancel, raw_start, raw_sensor};
    if (rst) begin
      m_edge = 0;
      q_raw  = {4'b0, 4'b0};
      for (int c = 0; c < 4; c++) begin
        m_level[c] = 1'b0;
        m_run[c]   = 0;
        m_cand[c]  = 1'b0;
      end
      e_tick = 0; e_sensor = 0; e_start = 0; e_cancel = 0; e_test = 0;
      return;
    end
    // Candidates accepted on the previous edge become pulses now.
    e_cancel = m_cand[2];
    e_start  = m_cand[1] && !m_cand[2];
    e_test   = m_cand[3] && !m_cand[1] && !m_cand[2];
    for (int c = 0; c < 4; c++) m_cand[c] = 1'b0;
    m_edge++;
    // Value seen by the debouncer is the raw input from two edges earlier.
    synced = q_raw[0];
    q_raw.push_back(raw_now);
    void'(q_raw.pop_front());
    if (m_edge % CLK_DIV == 0) begin
      for (int c = 0; c < 4; c++) begin
        if (synced[c] == m_level[c]) begin
          m_run[c] = 0;
        end else begin
          m_run[c]++;
          if (m_run[c] >= need(c)) begin
            m_level[c] = !m_level[c];
            m_run[c]   = 0;
            if (c > 0 && m_level[c]) m_cand[c] = 1'b1;
          end
        end
      end
    end
    e_tick   = (m_edge % CLK_DIV == CLK_DIV - 1);
    e_sensor = m_level[0];
  endtask

  task automatic chk(string tag, logic obs, logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, m_edge, obs, exp);
    end
  endtask

  // One clock: update the model at the edge, compare 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("tick", tick, e_tick);
    chk("sensor_o", sensor_o, e_sensor);
    chk("start_p", start_p, e_start);
    chk("cancel_p", cancel_p, e_cancel);
    chk("test_p", test_p, e_test);
    chk("onehot", logic'($countones({start_p, cancel_p, test_p}) <= 1), 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  int n_start, n_cancel, n_test;

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) cycle();
    $display("step reset: outputs after reset checked");

    // Tick period, held start button, sensor on/off thresholds
    raw_start  = 1'b1;
    raw_sensor = 1'b1;
    rst = 1'b0;
    for (int e = 1; e <= 44; e++) begin
      cycle();
      chk("tick_period", tick, logic'(e % 4 == 3));
      chk("start_once", start_p, logic'(e == 13));
      chk("sensor_level", sensor_o, logic'(e >= 8 && e < 40));
      if (e == 20) raw_sensor = 1'b0;
    end
    $display("step held start / sensor thresholds done");

    // Cancel glitches (one sample, then two samples), then a real press
    raw_start  = 1'b0;
    raw_sensor = 1'b0;
    raw_cancel = 1'b1;
    do_reset();
    for (int e = 1; e <= 60; e++) begin
      cycle();
      chk("cancel_glitch", cancel_p, logic'(e == 53));
      if (e == 3)  raw_cancel = 1'b0;
      if (e == 16) raw_cancel = 1'b1;
      if (e == 23) raw_cancel = 1'b0;
      if (e == 40) raw_cancel = 1'b1;
    end
    $display("step cancel glitch rejection done");

    // Start and cancel together: cancel wins, start dropped
    raw_cancel = 1'b0;
    do_reset();
    raw_start  = 1'b1;
    raw_cancel = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      cycle();
      chk("coinc_cancel", cancel_p, logic'(e == 13));
      chk("coinc_start", start_p, 1'b0);
    end
    $display("step start+cancel coincidence done");

    // Test held across a reset in the middle of debouncing
    raw_start  = 1'b0;
    raw_cancel = 1'b0;
    do_reset();
    raw_test = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      cycle();
      chk("test_prereset", test_p, 1'b0);
    end
    do_reset();
    for (int e = 1; e <= 20; e++) begin
      cycle();
      chk("test_postreset", test_p, logic'(e == 13));
    end
    raw_test = 1'b0;
    $display("step test held across reset done");

    // Randomized run against the model
    n_start = 0; n_cancel = 0; n_test = 0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 11) == 0) raw_sensor = ~raw_sensor;
      if ($urandom_range(0, 11) == 0) raw_start  = ~raw_start;
      if ($urandom_range(0, 11) == 0) raw_cancel = ~raw_cancel;
      if ($urandom_range(0, 11) == 0) raw_test   = ~raw_test;
      cycle();
      n_start  += int'(e_start);
      n_cancel += int'(e_cancel);
      n_test   += int'(e_test);
    end
    rst = 1'b0;
    $display("step random: expected pulses start=%0d cancel=%0d test=%0d", n_start, n_cancel, n_test);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
